// File: rtl/braun_pkg.sv
// Shared definitions for the sequential shift-add multiplier slice.
//   ctrl_state_t  : controller state encoding (IDLE, RUN, DONE), 2 bits
//   DEFAULT_WIDTH : default operand width used by the controller
package braun_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/braun_seq_mult_ctrl_rca.sv
// Ripple-carry adder built from full_adder cells. The multiplier controller
// time-shares a single instance of it across every iteration.
//   full_adder : a, b, cin -> sum, cout (one bit)
//   rca_adder  : a[WIDTH], b[WIDTH], cin -> sum[WIDTH], cout (purely combinational)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module rca_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        full_adder u_fa (
            .a    (a[gi]),
            .b    (b[gi]),
            .cin  (carry[gi]),
            .sum  (sum[gi]),
            .cout (carry[gi+1])
        );
    end

    assign cout = carry[WIDTH];
endmodule

// File: rtl/braun_seq_mult_ctrl.sv
// Sequential shift-add unsigned multiplier controller. One WIDTH-bit adder is
// reused for WIDTH iterations; operands and product move over valid/ready.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_ready high only in IDLE)
//   a, b                : multiplicand / multiplier, unsigned
//   abort               : cancel the operation in RUN or DONE
//   out_valid/out_ready : product handshake (out_valid high only in DONE)
//   product             : a*b, held while out_valid and kept in IDLE
//   busy                : high in RUN or DONE
module braun_seq_mult_ctrl
    import braun_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    ctrl_state_t        state_reg, state_next;
    logic [CNT_W-1:0]   count_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [2*WIDTH:0]   p_reg;
    logic [2*WIDTH-1:0] product_reg;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic [2*WIDTH:0]   p_step;
    logic               accept;
    logic               last_iter;
    logic               p_msb_unused;

    assign accept    = (state_reg == IDLE) && in_valid;
    assign last_iter = (count_reg == CNT_W'(WIDTH - 1));

    // Add the multiplicand into the upper half only when the current
    // multiplier bit (P[0]) is set; otherwise the adder passes hi through.
    assign addend = p_reg[0] ? a_reg : '0;

    rca_adder #(.WIDTH(WIDTH)) u_rca (
        .a    (p_reg[2*WIDTH-1:WIDTH]),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry)
    );

    // {0, carry, sum, lo} >> 1: the carry lands in bit 2W before the shift,
    // so nothing is lost and the top bit of P always ends up zero.
    assign p_step = {1'b0, carry, sum, p_reg[WIDTH-1:1]};

    // Top bit of P is structurally zero after every step; kept for the
    // register shape but never consumed.
    assign p_msb_unused = p_reg[2*WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                // abort is deliberately ignored here
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (abort)          state_next = IDLE;
                else if (last_iter) state_next = DONE;
            end
            DONE: begin
                if (abort || out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg   <= '0;
            a_reg       <= '0;
            p_reg       <= '0;
            product_reg <= '0;
        end else if (accept) begin
            a_reg     <= a;
            p_reg     <= {1'b0, {WIDTH{1'b0}}, b};
            count_reg <= '0;
        end else if ((state_reg == RUN) && !abort) begin
            p_reg     <= p_step;
            count_reg <= count_reg + CNT_W'(1);
            // Capture the finished product on the final iteration so it is
            // valid on the same edge that enters DONE.
            if (last_iter) product_reg <= p_step[2*WIDTH-1:0];
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign product   = product_reg;

endmodule

// File: tb/tb_braun_seq_mult_ctrl.sv
module tb_braun_seq_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        abort = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] product;
    logic        busy;

    logic        in_valid_4 = 1'b0;
    logic        in_ready_4;
    logic [3:0]  a_4 = '0;
    logic [3:0]  b_4 = '0;
    logic        abort_4 = 1'b0;
    logic        out_valid_4;
    logic        out_ready_4 = 1'b0;
    logic [7:0]  product_4;
    logic        busy_4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    braun_seq_mult_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    braun_seq_mult_ctrl #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_4),
        .in_ready  (in_ready_4),
        .a         (a_4),
        .b         (b_4),
        .abort     (abort_4),
        .out_valid (out_valid_4),
        .out_ready (out_ready_4),
        .product   (product_4),
        .busy      (busy_4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until out_valid rises (bounded at 40).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // Drives one operand pair, measures latency, captures and drains product.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                          output logic [15:0] prod, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        a = ia;
        b = ib;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        prod = product;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 16'd0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b product=%0d, want 1 0 0 0",
                     in_ready, out_valid, busy, product);
        end
        checks++;
        if (in_ready_4 !== 1'b1 || out_valid_4 !== 1'b0 || product_4 !== 8'd0) begin
            errors++;
            $display("FAIL reset_w4: in_ready=%b out_valid=%b product=%0d, want 1 0 0",
                     in_ready_4, out_valid_4, product_4);
        end
        rst = 1'b0;
        tick();
        $display("reset done");
    endtask

    task automatic test_basic();
        int lat;
        a = 8'd13;
        b = 8'd11;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_accept: in_ready=%b busy=%b, want 0 1", in_ready, busy);
        end
        wait_valid(lat);
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 8", lat);
        end
        checks++;
        if (product !== 16'd143) begin
            errors++;
            $display("FAIL basic_product: got %0d want 143", product);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || product !== 16'd143) begin
            errors++;
            $display("FAIL basic_drain: out_valid=%b in_ready=%b busy=%b product=%0d, want 0 1 0 143",
                     out_valid, in_ready, busy, product);
        end
        $display("basic 13*11 -> %0d latency %0d", product, lat);
    endtask

    task automatic test_corners();
        logic [7:0]  va [3];
        logic [7:0]  vb [3];
        logic [15:0] ve [3];
        logic [15:0] got;
        int lat;
        va[0] = 8'd255; vb[0] = 8'd255; ve[0] = 16'd65025;
        va[1] = 8'd0;   vb[1] = 8'd200; ve[1] = 16'd0;
        va[2] = 8'd200; vb[2] = 8'd1;   ve[2] = 16'd200;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], got, lat);
            checks++;
            if (got !== ve[i] || lat != 8) begin
                errors++;
                $display("FAIL corner_%0d: %0d*%0d got %0d lat %0d, want %0d lat 8",
                         i, va[i], vb[i], got, lat, ve[i]);
            end
            $display("corner %0d*%0d -> %0d latency %0d", va[i], vb[i], got, lat);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        a = 8'd100;
        b = 8'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        checks++;
        if (lat != 8 || product !== 16'd300) begin
            errors++;
            $display("FAIL bp_first: product=%0d lat=%0d, want 300 lat 8", product, lat);
        end
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b0;
            in_valid  = (i % 2 == 0);
            a = 8'd7;
            b = 8'd7;
            tick();
            checks++;
            if (out_valid !== 1'b1 || product !== 16'd300 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: out_valid=%b product=%0d in_ready=%b, want 1 300 0",
                         i, out_valid, product, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 16'd300) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b product=%0d, want 0 1 300",
                     out_valid, in_ready, product);
        end
        $display("backpressure 100*3 -> %0d held 5 cycles", product);
    endtask

    task automatic test_abort();
        int lat;
        bit seen;
        logic [15:0] got;
        a = 8'd77;
        b = 8'd9;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_run: in_ready=%b busy=%b out_valid=%b, want 1 0 0",
                     in_ready, busy, out_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_valid: out_valid rose after abort, want never");
        end
        run_op(8'd5, 8'd6, got, lat);
        checks++;
        if (got !== 16'd30 || lat != 8) begin
            errors++;
            $display("FAIL abort_next: got %0d lat %0d, want 30 lat 8", got, lat);
        end
        // abort while DONE wins over out_ready
        a = 8'd2;
        b = 8'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        abort = 1'b1;
        out_ready = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || lat != 8) begin
            errors++;
            $display("FAIL abort_done: out_valid=%b in_ready=%b lat=%0d, want 0 1 8",
                     out_valid, in_ready, lat);
        end
        // abort in IDLE does not block an accept
        a = 8'd4;
        b = 8'd4;
        in_valid = 1'b1;
        abort = 1'b1;
        tick();
        in_valid = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle_accept: busy=%b, want 1", busy);
        end
        wait_valid(lat);
        checks++;
        if (product !== 16'd16 || lat != 8) begin
            errors++;
            $display("FAIL abort_idle_product: got %0d lat %0d, want 16 lat 8", product, lat);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("abort scenarios: follow-up 5*6 -> %0d", got);
    endtask

    task automatic test_rst_mid();
        int lat;
        logic [15:0] got;
        a = 8'd50;
        b = 8'd50;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 16'd0) begin
            errors++;
            $display("FAIL rst_run: in_ready=%b out_valid=%b busy=%b product=%0d, want 1 0 0 0",
                     in_ready, out_valid, busy, product);
        end
        a = 8'd7;
        b = 8'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 16'd0 || lat != 8) begin
            errors++;
            $display("FAIL rst_done: in_ready=%b out_valid=%b busy=%b product=%0d lat=%0d, want 1 0 0 0 8",
                     in_ready, out_valid, busy, product, lat);
        end
        run_op(8'd12, 8'd12, got, lat);
        checks++;
        if (got !== 16'd144 || lat != 8) begin
            errors++;
            $display("FAIL rst_after: got %0d lat %0d, want 144 lat 8", got, lat);
        end
        $display("reset mid-op: follow-up 12*12 -> %0d", got);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ia, ib;
        logic [15:0] got, exp;
        int lat, n;
        bit drained, held;
        int bad;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            ia = 8'($urandom_range(0, 255));
            ib = 8'($urandom_range(0, 255));
            exp = 16'(int'(ia) * int'(ib));
            n = 0;
            while (!in_ready && n < 40) begin
                tick();
                n++;
            end
            a = ia;
            b = ib;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            wait_valid(lat);
            got = product;
            drained = 1'b0;
            held = 1'b1;
            n = 0;
            while (!drained && n < 40) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
                if (out_ready) drained = 1'b1;
                else if (out_valid !== 1'b1 || product !== got) held = 1'b0;
                n++;
            end
            out_ready = 1'b0;
            checks++;
            if (got !== exp || lat != 8 || !drained || !held) begin
                errors++;
                bad++;
                $display("FAIL stream_%0d: %0d*%0d got %0d lat %0d drained %0d held %0d, want %0d lat 8",
                         i, ia, ib, got, lat, drained, held, exp);
            end
        end
        $display("stream of 1000 pairs: %0d bad", bad);
    endtask

    task automatic test_width4();
        logic [3:0] va [3];
        logic [3:0] vb [3];
        logic [7:0] ve [3];
        int lat;
        va[0] = 4'd15; vb[0] = 4'd15; ve[0] = 8'd225;
        va[1] = 4'd9;  vb[1] = 4'd7;  ve[1] = 8'd63;
        va[2] = 4'd0;  vb[2] = 4'd15; ve[2] = 8'd0;
        for (int i = 0; i < 3; i++) begin
            a_4 = va[i];
            b_4 = vb[i];
            in_valid_4 = 1'b1;
            tick();
            in_valid_4 = 1'b0;
            lat = 0;
            while (!out_valid_4 && lat < 40) begin
                tick();
                lat++;
            end
            checks++;
            if (product_4 !== ve[i] || lat != 4) begin
                errors++;
                $display("FAIL w4_%0d: %0d*%0d got %0d lat %0d, want %0d lat 4",
                         i, va[i], vb[i], product_4, lat, ve[i]);
            end
            $display("width4 %0d*%0d -> %0d latency %0d", va[i], vb[i], product_4, lat);
            out_ready_4 = 1'b1;
            tick();
            out_ready_4 = 1'b0;
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_abort();
        test_rst_mid();
        test_back_to_back();
        test_width4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
